bram_arb_34_11: RTL and testbench

- Two-client arbiter that shares one 34-bit x 2048-entry simple dual-port BRAM (one write port, one read port, registered read address, 1-cycle read latency) between the NTT butterfly engine (client A) and the host load/unload path (client B).
- Write port and read port are arbitrated independently, each round-robin with optional burst lock.
- Returns read data with a per-client valid strobe.
- Sits between the NTT core/host interface and the BRAM macro.

---
 rtl/bram_arb_34_11_pkg.sv | 21 ++
 rtl/bram_arb_port_rr.sv | 72 +++++++
 rtl/bram_arb_34_11.sv | 139 +++++++++++++
 tb/tb_bram_arb_34_11.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_34_11_pkg.sv
// Shared definitions for the BRAM arbiter: default geometry, the per-port
// arbitration state encoding and the stall counter helpers used when the
// optional BRAM_ARB_PERF_EN build is selected.
package bram_arb_34_11_pkg;

    localparam int DW_DEF  = 34;
    localparam int AW_DEF  = 11;
    localparam int STALL_W = 16;

    typedef enum logic [1:0] {
        IDLE_RR = 2'd0,
        OWN_A   = 2'd1,
        OWN_B   = 2'd2
    } arb_state_t;

    // Saturating increment for the stall counters.
    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/bram_arb_port_rr.sv
// Two-requester round-robin arbiter with burst lock. Bit 0 is client A,
// bit 1 is client B. A grant is combinational from req and the registered
// state; the transfer happens on the cycle where req and gnt are both high.
// A lock is only honoured on a cycle where its owner is granted; the owner
// then keeps exclusive grant until it drops its lock or its request.
// The pointer only moves on a tie resolved in IDLE_RR.
module bram_arb_port_rr
    import bram_arb_34_11_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output arb_state_t state_dbg
);

    arb_state_t state_q, state_d;
    logic       ptr_q, ptr_d;   // 0: A wins the next tie, 1: B wins

    // State and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE_RR;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Grant decode and next-state logic.
    always_comb begin
        gnt     = 2'b00;
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE_RR: begin
                if (req == 2'b11) begin
                    gnt   = ptr_q ? 2'b10 : 2'b01;
                    ptr_d = ~ptr_q;
                end else begin
                    gnt = req;
                end
                if (gnt[0] && lock[0]) begin
                    state_d = OWN_A;
                end else if (gnt[1] && lock[1]) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                // B stays blocked even on a cycle where A idles.
                gnt[0] = req[0];
                if (!(req[0] && lock[0])) begin
                    state_d = IDLE_RR;
                end
            end
            OWN_B: begin
                gnt[1] = req[1];
                if (!(req[1] && lock[1])) begin
                    state_d = IDLE_RR;
                end
            end
            default: begin
                state_d = IDLE_RR;
            end
        endcase
    end

    assign state_dbg = state_q;

endmodule

// File: rtl/bram_arb_34_11.sv
// Shares one simple dual-port BRAM (registered read address, 1-cycle read
// latency, write-first on same-address collisions) between the NTT engine
// (client A) and the host load/unload path (client B). Write and read ports
// are arbitrated independently by two bram_arb_port_rr instances.
// Optional macro BRAM_ARB_PERF_EN adds per-client saturating stall counters
// with a synchronous clear (perf_clr).
//
// Handshake: a client holds x_req (with its address/data) until it sees
// x_gnt high in the same cycle; that cycle is the transfer. For reads,
// x_rd_vld rises exactly one cycle after x_rd_gnt and qualifies rd_data.
module bram_arb_34_11
    import bram_arb_34_11_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_wr_req,
    input  logic          a_wr_lock,
    input  logic [AW-1:0] a_wr_addr,
    input  logic [DW-1:0] a_wr_din,
    output logic          a_wr_gnt,
    input  logic          a_rd_req,
    input  logic          a_rd_lock,
    input  logic [AW-1:0] a_rd_addr,
    output logic          a_rd_gnt,
    output logic          a_rd_vld,
    input  logic          b_wr_req,
    input  logic          b_wr_lock,
    input  logic [AW-1:0] b_wr_addr,
    input  logic [DW-1:0] b_wr_din,
    output logic          b_wr_gnt,
    input  logic          b_rd_req,
    input  logic          b_rd_lock,
    input  logic [AW-1:0] b_rd_addr,
    output logic          b_rd_gnt,
    output logic          b_rd_vld,
`ifdef BRAM_ARB_PERF_EN
    input  logic               perf_clr,
    output logic [STALL_W-1:0] a_stall_cnt,
    output logic [STALL_W-1:0] b_stall_cnt,
`endif
    output logic [DW-1:0] rd_data,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_din,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_dout
);

    logic [1:0]    wr_gnt, rd_gnt;
    arb_state_t    wr_state_unused, rd_state_unused;
    logic [AW-1:0] rd_addr_q;

    bram_arb_port_rr u_wr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({b_wr_req, a_wr_req}),
        .lock      ({b_wr_lock, a_wr_lock}),
        .gnt       (wr_gnt),
        .state_dbg (wr_state_unused)
    );

    bram_arb_port_rr u_rd_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({b_rd_req, a_rd_req}),
        .lock      ({b_rd_lock, a_rd_lock}),
        .gnt       (rd_gnt),
        .state_dbg (rd_state_unused)
    );

    assign a_wr_gnt = wr_gnt[0];
    assign b_wr_gnt = wr_gnt[1];
    assign a_rd_gnt = rd_gnt[0];
    assign b_rd_gnt = rd_gnt[1];

    // Write mux: granted client's address/data, zero when nobody writes.
    always_comb begin
        mem_wr_en   = a_wr_gnt | b_wr_gnt;
        mem_wr_addr = '0;
        mem_wr_din  = '0;
        if (a_wr_gnt) begin
            mem_wr_addr = a_wr_addr;
            mem_wr_din  = a_wr_din;
        end else if (b_wr_gnt) begin
            mem_wr_addr = b_wr_addr;
            mem_wr_din  = b_wr_din;
        end
    end

    // Read address mux: hold the last address when idle so rd_data is stable.
    always_comb begin
        mem_rd_addr = rd_addr_q;
        if (a_rd_gnt) begin
            mem_rd_addr = a_rd_addr;
        end else if (b_rd_gnt) begin
            mem_rd_addr = b_rd_addr;
        end
    end

    // Last read address and per-client read-valid strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            a_rd_vld  <= 1'b0;
            b_rd_vld  <= 1'b0;
        end else begin
            rd_addr_q <= mem_rd_addr;
            a_rd_vld  <= a_rd_gnt;
            b_rd_vld  <= b_rd_gnt;
        end
    end

    assign rd_data = mem_rd_dout;

`ifdef BRAM_ARB_PERF_EN
    logic a_stall, b_stall;

    assign a_stall = (a_wr_req & ~a_wr_gnt) | (a_rd_req & ~a_rd_gnt);
    assign b_stall = (b_wr_req & ~b_wr_gnt) | (b_rd_req & ~b_rd_gnt);

    // Saturating stall counters, cleared by reset or perf_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_stall_cnt <= '0;
            b_stall_cnt <= '0;
        end else if (perf_clr) begin
            a_stall_cnt <= '0;
            b_stall_cnt <= '0;
        end else begin
            if (a_stall) a_stall_cnt <= sat_inc(a_stall_cnt);
            if (b_stall) b_stall_cnt <= sat_inc(b_stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_bram_arb_34_11.sv
// Directed bench for bram_arb_34_11: a table of per-cycle vectors (requests
// plus hand-computed grants and read data) driven through a behavioural
// write-first BRAM, followed by hand-written reset and stall-counter sequences.
module tb_bram_arb_34_11;

    localparam int DW = 34;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_wr_req = 0, a_wr_lock = 0, a_rd_req = 0, a_rd_lock = 0;
    logic          b_wr_req = 0, b_wr_lock = 0, b_rd_req = 0, b_rd_lock = 0;
    logic [AW-1:0] a_wr_addr = '0, b_wr_addr = '0, a_rd_addr = '0, b_rd_addr = '0;
    logic [DW-1:0] a_wr_din = '0, b_wr_din = '0;
    logic          a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt, a_rd_vld, b_rd_vld;
    logic [DW-1:0] rd_data, mem_wr_din, mem_rd_dout;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
`ifdef BRAM_ARB_PERF_EN
    logic          perf_clr = 1'b0;
    logic [15:0]   a_stall_cnt, b_stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // clock/reset block
    always #5 clk = ~clk;

    bram_arb_34_11 dut (
        .clk (clk), .rst_n (rst_n),
        .a_wr_req (a_wr_req), .a_wr_lock (a_wr_lock), .a_wr_addr (a_wr_addr),
        .a_wr_din (a_wr_din), .a_wr_gnt (a_wr_gnt),
        .a_rd_req (a_rd_req), .a_rd_lock (a_rd_lock), .a_rd_addr (a_rd_addr),
        .a_rd_gnt (a_rd_gnt), .a_rd_vld (a_rd_vld),
        .b_wr_req (b_wr_req), .b_wr_lock (b_wr_lock), .b_wr_addr (b_wr_addr),
        .b_wr_din (b_wr_din), .b_wr_gnt (b_wr_gnt),
        .b_rd_req (b_rd_req), .b_rd_lock (b_rd_lock), .b_rd_addr (b_rd_addr),
        .b_rd_gnt (b_rd_gnt), .b_rd_vld (b_rd_vld),
`ifdef BRAM_ARB_PERF_EN
        .perf_clr (perf_clr), .a_stall_cnt (a_stall_cnt), .b_stall_cnt (b_stall_cnt),
`endif
        .rd_data (rd_data), .mem_wr_en (mem_wr_en), .mem_wr_addr (mem_wr_addr),
        .mem_wr_din (mem_wr_din), .mem_rd_addr (mem_rd_addr), .mem_rd_dout (mem_rd_dout)
    );

    // Behavioural BRAM: registered read, write-first on address collision.
    logic [DW-1:0] mem [2**AW];
    initial begin
        for (int i = 0; i < 2**AW; i++) mem[i] = '0;
        mem_rd_dout = '0;
    end
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_din;
        mem_rd_dout <= (mem_wr_en && mem_wr_addr == mem_rd_addr) ? mem_wr_din : mem[mem_rd_addr];
    end

    typedef struct {
        string         name;
        logic          a_wr, a_wl;
        logic [AW-1:0] a_wa;
        logic [DW-1:0] a_wd;
        logic          b_wr, b_wl;
        logic [AW-1:0] b_wa;
        logic [DW-1:0] b_wd;
        logic          a_rd, a_rl;
        logic [AW-1:0] a_ra;
        logic          b_rd, b_rl;
        logic [AW-1:0] b_ra;
        logic          e_awg, e_bwg, e_arg, e_brg;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t nop(input string n);
        vec_t v;
        v.name = n;
        v.a_wr = 0; v.a_wl = 0; v.a_wa = '0; v.a_wd = '0;
        v.b_wr = 0; v.b_wl = 0; v.b_wa = '0; v.b_wd = '0;
        v.a_rd = 0; v.a_rl = 0; v.a_ra = '0;
        v.b_rd = 0; v.b_rl = 0; v.b_ra = '0;
        v.e_awg = 0; v.e_bwg = 0; v.e_arg = 0; v.e_brg = 0;
        v.e_rdata = '0;
        return v;
    endfunction

    // scoreboard compare
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // driver: apply one vector at a negedge, check comb outputs, then the
    // registered read results at the following negedge
    task automatic apply(input vec_t v);
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        a_wr_req = v.a_wr; a_wr_lock = v.a_wl; a_wr_addr = v.a_wa; a_wr_din = v.a_wd;
        b_wr_req = v.b_wr; b_wr_lock = v.b_wl; b_wr_addr = v.b_wa; b_wr_din = v.b_wd;
        a_rd_req = v.a_rd; a_rd_lock = v.a_rl; a_rd_addr = v.a_ra;
        b_rd_req = v.b_rd; b_rd_lock = v.b_rl; b_rd_addr = v.b_ra;
        e_wa = v.e_awg ? v.a_wa : (v.e_bwg ? v.b_wa : '0);
        e_wd = v.e_awg ? v.a_wd : (v.e_bwg ? v.b_wd : '0);
        #1;
        chk({v.name, " a_wr_gnt"}, 64'(a_wr_gnt), 64'(v.e_awg));
        chk({v.name, " b_wr_gnt"}, 64'(b_wr_gnt), 64'(v.e_bwg));
        chk({v.name, " mem_wr_en"}, 64'(mem_wr_en), 64'(v.e_awg | v.e_bwg));
        chk({v.name, " mem_wr_addr"}, 64'(mem_wr_addr), 64'(e_wa));
        chk({v.name, " mem_wr_din"}, 64'(mem_wr_din), 64'(e_wd));
        chk({v.name, " a_rd_gnt"}, 64'(a_rd_gnt), 64'(v.e_arg));
        chk({v.name, " b_rd_gnt"}, 64'(b_rd_gnt), 64'(v.e_brg));
        if (v.e_arg) chk({v.name, " mem_rd_addr"}, 64'(mem_rd_addr), 64'(v.a_ra));
        else if (v.e_brg) chk({v.name, " mem_rd_addr"}, 64'(mem_rd_addr), 64'(v.b_ra));
        @(posedge clk);
        @(negedge clk);
        chk({v.name, " a_rd_vld"}, 64'(a_rd_vld), 64'(v.e_arg));
        chk({v.name, " b_rd_vld"}, 64'(b_rd_vld), 64'(v.e_brg));
        if (v.e_arg | v.e_brg) chk({v.name, " rd_data"}, 64'(rd_data), 64'(v.e_rdata));
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        // ---------------- vector table ----------------
        // preload 0..3 through A, alone
        for (int k = 0; k < 4; k++) begin
            v = nop($sformatf("t1 wr%0d", k));
            v.a_wr = 1; v.a_wa = 11'(k); v.a_wd = 34'h1_2345_0000 + 34'(k); v.e_awg = 1;
            vecs.push_back(v);
        end
        // test 1: A reads 0..3 back to back
        for (int k = 0; k < 4; k++) begin
            v = nop($sformatf("t1 rd%0d", k));
            v.a_rd = 1; v.a_ra = 11'(k); v.e_arg = 1; v.e_rdata = 34'h1_2345_0000 + 34'(k);
            vecs.push_back(v);
        end
        vecs.push_back(nop("t1 idle"));
        // test 2: write contention, alternating from A; B's lock on a lost cycle is ignored
        for (int k = 0; k < 5; k++) begin
            v = nop($sformatf("t2 wr%0d", k));
            v.a_wr = 1; v.a_wa = 11'(16 + k); v.a_wd = 34'h0_AAAA_0000 + 34'(k);
            v.b_wr = 1; v.b_wa = 11'(32 + k); v.b_wd = 34'h2_BBBB_0000 + 34'(k);
            v.b_wl = (k == 0);
            v.e_awg = (k % 2 == 0); v.e_bwg = (k % 2 == 1);
            vecs.push_back(v);
        end
        // read back the interleaved result
        v = nop("t2 rd10"); v.a_rd = 1; v.a_ra = 11'h010; v.e_arg = 1; v.e_rdata = 34'h0_AAAA_0000; vecs.push_back(v);
        v = nop("t2 rd11"); v.a_rd = 1; v.a_ra = 11'h011; v.e_arg = 1; v.e_rdata = 34'h0; vecs.push_back(v);
        v = nop("t2 rd14"); v.a_rd = 1; v.a_ra = 11'h014; v.e_arg = 1; v.e_rdata = 34'h0_AAAA_0004; vecs.push_back(v);
        v = nop("t2 rd21"); v.b_rd = 1; v.b_ra = 11'h021; v.e_brg = 1; v.e_rdata = 34'h2_BBBB_0001; vecs.push_back(v);
        v = nop("t2 rd23"); v.b_rd = 1; v.b_ra = 11'h023; v.e_brg = 1; v.e_rdata = 34'h2_BBBB_0003; vecs.push_back(v);
        // read lock: A owns, idles with lock high, B stays blocked that cycle
        v = nop("rl own"); v.a_rd = 1; v.a_rl = 1; v.a_ra = 11'h000; v.e_arg = 1; v.e_rdata = 34'h1_2345_0000; vecs.push_back(v);
        v = nop("rl hold"); v.a_rl = 1; v.b_rd = 1; v.b_ra = 11'h001; vecs.push_back(v);
        v = nop("rl free"); v.b_rd = 1; v.b_ra = 11'h001; v.e_brg = 1; v.e_rdata = 34'h1_2345_0001; vecs.push_back(v);
        // test 3: B locked burst of 8 against a waiting A (write pointer favours B here)
        for (int k = 0; k < 10; k++) begin
            v = nop($sformatf("t3 wr%0d", k));
            v.a_wr = (k < 9); v.a_wa = 11'h050; v.a_wd = 34'h0_5050_5050;
            v.b_wr = 1; v.b_wa = 11'h100 + 11'(k > 8 ? 8 : k); v.b_wd = 34'h3_0000_0100 + 34'(k > 8 ? 8 : k);
            v.b_wl = (k < 7);
            v.e_awg = (k == 8); v.e_bwg = (k != 8);
            vecs.push_back(v);
        end
        v = nop("t3 rd100"); v.b_rd = 1; v.b_ra = 11'h100; v.e_brg = 1; v.e_rdata = 34'h3_0000_0100; vecs.push_back(v);
        v = nop("t3 rd107"); v.b_rd = 1; v.b_ra = 11'h107; v.e_brg = 1; v.e_rdata = 34'h3_0000_0107; vecs.push_back(v);
        v = nop("t3 rd108"); v.b_rd = 1; v.b_ra = 11'h108; v.e_brg = 1; v.e_rdata = 34'h3_0000_0108; vecs.push_back(v);
        v = nop("t3 rd050"); v.a_rd = 1; v.a_ra = 11'h050; v.e_arg = 1; v.e_rdata = 34'h0_5050_5050; vecs.push_back(v);
        // test 4: same-address write and read in one cycle
        v = nop("t4 coll");
        v.a_wr = 1; v.a_wa = 11'h7FF; v.a_wd = 34'h3_FFFF_FFFF; v.e_awg = 1;
        v.b_rd = 1; v.b_ra = 11'h7FF; v.e_brg = 1; v.e_rdata = 34'h3_FFFF_FFFF;
        vecs.push_back(v);
        vecs.push_back(nop("t4 idle"));

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst a_rd_vld", 64'(a_rd_vld), 64'd0);
        chk("rst b_rd_vld", 64'(b_rd_vld), 64'd0);
        chk("rst mem_wr_en", 64'(mem_wr_en), 64'd0);
        chk("rst gnts", 64'({a_wr_gnt, b_wr_gnt, a_rd_gnt, b_rd_gnt}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i]);

        // ---------------- test 5: reset mid-burst ----------------
        a_rd_req = 1; a_rd_lock = 1; a_rd_addr = 11'h002;
        @(posedge clk);
        @(negedge clk);
        chk("t5 inflight vld", 64'(a_rd_vld), 64'd1);
        chk("t5 inflight data", 64'(rd_data), 64'h1_2345_0002);
        #2 rst_n = 1'b0;
        #1;
        chk("t5 vld dropped", 64'(a_rd_vld), 64'd0);
        a_rd_req = 0; a_rd_lock = 0;
        #1;
        chk("t5 no gnt in rst", 64'({a_rd_gnt, b_rd_gnt, mem_wr_en}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = nop("t5 lock gone"); v.b_rd = 1; v.b_ra = 11'h003; v.e_brg = 1; v.e_rdata = 34'h1_2345_0003; apply(v);
        v = nop("t5 tie to A");
        v.a_rd = 1; v.a_ra = 11'h001; v.b_rd = 1; v.b_ra = 11'h002; v.e_arg = 1; v.e_rdata = 34'h1_2345_0001;
        apply(v);
        apply(nop("t5 idle"));

`ifdef BRAM_ARB_PERF_EN
        // ---------------- test 6: stall counters ----------------
        rst_n = 1'b0;
        #2;
        chk("t6 rst a_stall", 64'(a_stall_cnt), 64'd0);
        chk("t6 rst b_stall", 64'(b_stall_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            v = nop($sformatf("t6 wr%0d", k));
            v.a_wr = 1; v.a_wl = 1; v.a_wa = 11'h200 + 11'(k); v.a_wd = 34'(k);
            v.b_wr = 1; v.b_wa = 11'h300; v.b_wd = 34'h1;
            v.e_awg = 1;
            apply(v);
        end
        apply(nop("t6 idle"));
        chk("t6 a_stall", 64'(a_stall_cnt), 64'd0);
        chk("t6 b_stall", 64'(b_stall_cnt), 64'd10);
        perf_clr = 1'b1;
        b_rd_req = 1'b1; b_rd_addr = 11'h000;
        a_rd_req = 1'b1; a_rd_addr = 11'h000;
        @(posedge clk);
        @(negedge clk);
        perf_clr = 1'b0;
        a_rd_req = 1'b0; b_rd_req = 1'b0;
        chk("t6 clr a_stall", 64'(a_stall_cnt), 64'd0);
        chk("t6 clr b_stall", 64'(b_stall_cnt), 64'd0);
`endif

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
